sample_pairer: RTL and testbench

- Upstream feeder for the polyphase filter stage.
- Collects single DWIDTH-bit samples from a serial source via a four-phase req/ack handshake and packs consecutive samples x[2n], x[2n+1] into one DDWIDTH word.
- Buffers packed pairs in a small FIFO.
- Serves the filter's input request (filter drives request, this block drives acknowledge).

---
 rtl/sample_pairer_pkg.sv | 15 +
 rtl/pair_fifo.sv | 61 ++++++
 rtl/sample_pairer.sv | 155 +++++++++++++++
 tb/tb_sample_pairer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_pairer_pkg.sv
// rtl/sample_pairer_pkg.sv - state encodings shared by the sample pairer
package sample_pairer_pkg;

    typedef enum logic [1:0] {
        IN_IDLE = 2'd0,
        IN_REQ  = 2'd1,
        IN_REL  = 2'd2
    } in_state_t;

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_ACK  = 1'b1
    } out_state_t;

endpackage

// File: rtl/pair_fifo.sv
// rtl/pair_fifo.sv - synchronous FIFO of packed sample pairs
module pair_fifo
    import sample_pairer_pkg::*;
#(
    parameter int DDWIDTH = 32,
    parameter int AWIDTH  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [0:DDWIDTH-1] push_data,
    input  logic               pop,
    output logic [0:DDWIDTH-1] pop_data,
    output logic               full,
    output logic               empty,
    output logic [AWIDTH:0]    count
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH + 1)'(DEPTH);

    logic [0:DDWIDTH-1] mem [DEPTH];
    logic [AWIDTH-1:0]  wr_ptr;
    logic [AWIDTH-1:0]  rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage is not reset; count and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sample_pairer.sv
// rtl/sample_pairer.sv - packs req/ack sample pairs into a FIFO for the filter; SAMPLE_PAIRER_PAIR_CNT_EN adds pair_cnt
module sample_pairer
    import sample_pairer_pkg::*;
#(
    parameter int DWIDTH  = 16,
    parameter int DDWIDTH = 2 * DWIDTH,
    parameter int AWIDTH  = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               req_in,
    input  logic               ack_in,
    input  logic [0:DWIDTH-1]  data_in,
    input  logic               req_out,
    output logic               ack_out,
`ifdef SAMPLE_PAIRER_PAIR_CNT_EN
    output logic [0:DDWIDTH-1] data_out,
    output logic [0:15]        pair_cnt
`else
    output logic [0:DDWIDTH-1] data_out
`endif
);

    localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH + 1)'(1 << AWIDTH);

    in_state_t          in_state, in_next;
    out_state_t         out_state, out_next;
    logic               req_in_nxt;
    logic               ack_out_nxt;
    logic               capture;
    logic               phase;
    logic [0:DWIDTH-1]  hold;
    logic               push;
    logic               pop;
    logic [0:DDWIDTH-1] fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [AWIDTH:0]    fifo_count;

    pair_fifo #(
        .DDWIDTH(DDWIDTH),
        .AWIDTH (AWIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data({hold, data_in}),
        .pop      (pop),
        .pop_data (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Requests are only issued with room for a pair, so a phase-1 push never finds the FIFO full.
    always_comb begin
        in_next    = in_state;
        req_in_nxt = req_in;
        capture    = 1'b0;
        case (in_state)
            IN_IDLE: begin
                if (fifo_count < DEPTH_C) begin
                    req_in_nxt = 1'b1;
                    in_next    = IN_REQ;
                end
            end
            IN_REQ: begin
                if (ack_in) begin
                    capture    = 1'b1;
                    req_in_nxt = 1'b0;
                    in_next    = IN_REL;
                end
            end
            IN_REL: begin
                if (!ack_in) begin
                    in_next = IN_IDLE;
                end
            end
            default: begin
                req_in_nxt = 1'b0;
                in_next    = IN_IDLE;
            end
        endcase
    end

    assign push = capture && phase && !fifo_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_state <= IN_IDLE;
            req_in   <= 1'b0;
            phase    <= 1'b0;
            hold     <= '0;
        end else begin
            in_state <= in_next;
            req_in   <= req_in_nxt;
            if (capture) begin
                if (!phase) begin
                    hold <= data_in;
                end
                phase <= ~phase;
            end
        end
    end

    always_comb begin
        out_next    = out_state;
        ack_out_nxt = ack_out;
        pop         = 1'b0;
        case (out_state)
            OUT_IDLE: begin
                if (req_out && !fifo_empty) begin
                    pop         = 1'b1;
                    ack_out_nxt = 1'b1;
                    out_next    = OUT_ACK;
                end
            end
            OUT_ACK: begin
                if (!req_out) begin
                    ack_out_nxt = 1'b0;
                    out_next    = OUT_IDLE;
                end
            end
            default: begin
                ack_out_nxt = 1'b0;
                out_next    = OUT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_state <= OUT_IDLE;
            ack_out   <= 1'b0;
            data_out  <= '0;
        end else begin
            out_state <= out_next;
            ack_out   <= ack_out_nxt;
            if (pop) begin
                data_out <= fifo_head;
            end
        end
    end

`ifdef SAMPLE_PAIRER_PAIR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_cnt <= '0;
        end else if (pop) begin
            pair_cnt <= pair_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sample_pairer.sv
// tb/tb_sample_pairer.sv - self-checking bench for sample_pairer
module tb_sample_pairer;

    localparam int DW  = 16;
    localparam int DDW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_in;
    logic            ack_in = 1'b0;
    logic [0:DW-1]   data_in = '0;
    logic            req_out = 1'b0;
    logic            ack_out;
    logic [0:DDW-1]  data_out;
`ifdef SAMPLE_PAIRER_PAIR_CNT_EN
    logic [0:15]     pair_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sample_pairer dut (
        .clk     (clk),
        .rst     (rst),
        .req_in  (req_in),
        .ack_in  (ack_in),
        .data_in (data_in),
        .req_out (req_out),
        .ack_out (ack_out),
`ifdef SAMPLE_PAIRER_PAIR_CNT_EN
        .data_out(data_out),
        .pair_cnt(pair_cnt)
`else
        .data_out(data_out)
`endif
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] pair;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req_in(input logic v, input string who);
        for (int i = 0; i < 500; i++) begin
            if (req_in === v) break;
            tick();
        end
        check({who, " req_in wait"}, {31'd0, req_in}, {31'd0, v});
    endtask

    task automatic wait_ack_out(input logic v, input string who);
        for (int i = 0; i < 500; i++) begin
            if (ack_out === v) break;
            tick();
        end
        check({who, " ack_out wait"}, {31'd0, ack_out}, {31'd0, v});
    endtask

    task automatic src_send(input logic [15:0] v);
        wait_req_in(1'b1, "src");
        data_in = v;
        ack_in  = 1'b1;
        tick();
        wait_req_in(1'b0, "src release");
        ack_in = 1'b0;
    endtask

    task automatic sink_get(output logic [31:0] d);
        req_out = 1'b1;
        wait_ack_out(1'b1, "sink");
        d = data_out;
        req_out = 1'b0;
        tick();
        wait_ack_out(1'b0, "sink release");
    endtask

    // Reference: the k-th pair out must be {sample 2k, sample 2k+1} of everything sent.
    task automatic stream(input int npairs, input bit rnd, input string tag);
        logic [15:0] sent [$];
        logic [31:0] got  [$];
        fork
            begin
                for (int i = 0; i < 2 * npairs; i++) begin
                    logic [15:0] v;
                    v = rnd ? 16'($urandom) : 16'(i);
                    repeat ($urandom_range(0, 3)) tick();
                    src_send(v);
                    sent.push_back(v);
                end
            end
            begin
                for (int j = 0; j < npairs; j++) begin
                    logic [31:0] d;
                    repeat ($urandom_range(0, 6)) tick();
                    sink_get(d);
                    got.push_back(d);
                end
            end
        join
        check({tag, " pair count"}, got.size(), npairs);
        for (int k = 0; k < npairs && k < got.size(); k++) begin
            check($sformatf("%s pair %0d", tag, k), got[k], {sent[2*k], sent[2*k+1]});
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;

        vecs[0] = '{16'h0001, 16'h0002, 32'h0001_0002};
        vecs[1] = '{16'hFFFF, 16'h0000, 32'hFFFF_0000};
        vecs[2] = '{16'h8000, 16'h7FFF, 32'h8000_7FFF};
        vecs[3] = '{16'hA5A5, 16'h5A5A, 32'hA5A5_5A5A};

        rst = 1'b1;
        repeat (3) begin
            tick();
            check("reset req_in", {31'd0, req_in}, 32'd0);
            check("reset ack_out", {31'd0, ack_out}, 32'd0);
            check("reset data_out", data_out, 32'd0);
        end
        rst = 1'b0;
        tick();
        check("req_in after reset", {31'd0, req_in}, 32'd1);

        for (int i = 0; i < 4; i++) begin
            src_send(vecs[i].a);
            src_send(vecs[i].b);
            req_out = 1'b1;
            tick();
            check($sformatf("vec%0d ack latency", i), {31'd0, ack_out}, 32'd1);
            check($sformatf("vec%0d data", i), data_out, vecs[i].pair);
            req_out = 1'b0;
            tick();
            wait_ack_out(1'b0, "vec");
        end

        // Back-pressure: four pairs fill the FIFO and the source must be held off.
        for (int i = 0; i < 8; i++) begin
            src_send(16'(16'h0010 + i));
        end
        repeat (5) begin
            tick();
            check("full req_in held low", {31'd0, req_in}, 32'd0);
        end
        req_out = 1'b1;
        tick();
        check("full first pop ack", {31'd0, ack_out}, 32'd1);
        check("full first pop data", data_out, 32'h0010_0011);
        tick();
        check("full req_in re-raised", {31'd0, req_in}, 32'd1);
        req_out = 1'b0;
        wait_ack_out(1'b0, "full");
        for (int k = 1; k < 4; k++) begin
            sink_get(d);
            check($sformatf("full drain %0d", k), d, {16'(16'h0010 + 2*k), 16'(16'h0011 + 2*k)});
        end

        // Empty FIFO with a pending filter request.
        req_out = 1'b1;
        repeat (3) begin
            tick();
            check("empty no ack", {31'd0, ack_out}, 32'd0);
        end
        src_send(16'h0AAA);
        wait_req_in(1'b1, "empty second");
        data_in = 16'h0BBB;
        ack_in  = 1'b1;
        tick();
        check("empty capture", {31'd0, req_in}, 32'd0);
        check("empty ack not yet", {31'd0, ack_out}, 32'd0);
        tick();
        check("empty ack after push", {31'd0, ack_out}, 32'd1);
        check("empty data", data_out, 32'h0AAA_0BBB);
        ack_in  = 1'b0;
        req_out = 1'b0;
        tick();
        wait_ack_out(1'b0, "empty");

        // Push of the second sample and pop land on the same edge.
        src_send(16'h1111);
        src_send(16'h2222);
        src_send(16'h3333);
        wait_req_in(1'b1, "simul");
        data_in = 16'h4444;
        ack_in  = 1'b1;
        req_out = 1'b1;
        tick();
        check("simul ack", {31'd0, ack_out}, 32'd1);
        check("simul data", data_out, 32'h1111_2222);
        check("simul capture", {31'd0, req_in}, 32'd0);
        ack_in  = 1'b0;
        req_out = 1'b0;
        tick();
        wait_ack_out(1'b0, "simul");
        sink_get(d);
        check("simul second pair", d, 32'h3333_4444);
        req_out = 1'b1;
        repeat (3) begin
            tick();
            check("simul drained", {31'd0, ack_out}, 32'd0);
        end
        req_out = 1'b0;
        tick();

        stream(16, 1'b0, "wrap");
        stream(20, 1'b1, "rand");

        // Reset while a pair is being acknowledged and a partial pair is held.
        for (int i = 0; i < 5; i++) begin
            src_send(16'(16'h0100 + i));
        end
        req_out = 1'b1;
        tick();
        check("midrst ack before", {31'd0, ack_out}, 32'd1);
        check("midrst data before", data_out, 32'h0100_0101);
        rst     = 1'b1;
        req_out = 1'b0;
        tick();
        check("midrst ack_out", {31'd0, ack_out}, 32'd0);
        check("midrst req_in", {31'd0, req_in}, 32'd0);
        check("midrst data_out", data_out, 32'd0);
        rst     = 1'b0;
        tick();
        check("midrst req_in after", {31'd0, req_in}, 32'd1);
        req_out = 1'b1;
        repeat (3) begin
            tick();
            check("midrst fifo empty", {31'd0, ack_out}, 32'd0);
        end
        req_out = 1'b0;
        tick();
        src_send(16'h0200);
        src_send(16'h0201);
        sink_get(d);
        check("midrst fresh pair", d, 32'h0200_0201);
`ifdef SAMPLE_PAIRER_PAIR_CNT_EN
        check("pair_cnt after reset", {16'd0, pair_cnt}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
